// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, direct-mapped I-cache, single-word miss fill.
// Static JAL-taken prediction; redirects from execute override everything.
module if_fetch #(
  parameter int          ICACHE_IDX = 7,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        jmp_status_o
);

  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAGW  = 30 - ICACHE_IDX;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  logic [31:0] pc;
  logic [29:0] fill_addr;
  logic        state;

  logic [LINES-1:0] line_valid;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_IDX-1:0] idx;
  logic [TAGW-1:0]       tag;
  logic [ICACHE_IDX-1:0] fill_idx;
  logic [TAGW-1:0]       fill_tag;
  logic [31:0]           line;
  logic                  hit;
  logic                  is_jal;
  logic [31:0]           jimm;
  logic [31:0]           pc_next;
  logic                  fill_we;

  assign idx      = pc[ICACHE_IDX+1:2];
  assign tag      = pc[31:ICACHE_IDX+2];
  assign fill_idx = fill_addr[ICACHE_IDX-1:0];
  assign fill_tag = fill_addr[29:ICACHE_IDX];
  assign line     = data_mem[idx];
  assign hit      = line_valid[idx] && (tag_mem[idx] == tag);
  assign is_jal   = (line[6:0] == 7'b1101111);
  assign jimm     = {{11{line[31]}}, line[31], line[19:12],
                     line[20], line[30:21], 1'b0};
  assign pc_next  = is_jal ? pc + jimm : pc + 32'd4;
  assign fill_we  = rdy && (state == ST_WAIT) && mem_done_i;

  // PC and registered outputs: redirect > stall > hit > miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      valid_o      <= 1'b0;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      jmp_status_o <= 1'b0;
    end else if (rdy) begin
      if (jmp_i) begin
        pc      <= jmp_target_i;
        valid_o <= 1'b0;
      end else if (stall_i) begin
        pc      <= pc;
      end else if (hit) begin
        pc           <= pc_next;
        pc_o         <= pc;
        inst_o       <= line;
        valid_o      <= 1'b1;
        jmp_status_o <= is_jal;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

  // Miss machine; an issued request always runs to completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      fill_addr  <= 30'h0;
      line_valid <= '0;
    end else if (rdy) begin
      unique case (state)
        ST_IDLE: begin
          if (!hit && !jmp_i) begin
            state      <= ST_WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {pc[31:2], 2'b00};
            fill_addr  <= pc[31:2];
          end
        end
        ST_WAIT: begin
          if (mem_done_i) begin
            state                <= ST_IDLE;
            mem_req_o            <= 1'b0;
            line_valid[fill_idx] <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Cache tag/data arrays, written on fill completion
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data_i;
    end
  end

endmodule
